// File: rtl/integrador_saturado_pkg.sv
// Shared fixed-point format and helpers for the servo PID terms.
package integrador_saturado_pkg;

    // Fixed-point word: sign + MAGNITUD integer bits + DECIMAL fractional bits
    localparam int unsigned MAGNITUD = 18;
    localparam int unsigned DECIMAL  = 0;
    localparam int unsigned N        = MAGNITUD + DECIMAL + 1;
    localparam int unsigned NP       = 2 * N;

    typedef logic signed [N-1:0]  fixed_t;
    typedef logic signed [N:0]    sum_t;
    typedef logic signed [NP-1:0] wide_t;

    // Extremes of the N-bit signed range
    localparam fixed_t MAXV = fixed_t'({1'b0, {(N-1){1'b1}}});
    localparam fixed_t MINV = fixed_t'({1'b1, {(N-1){1'b0}}});

    // Stage-1 payload: scaled product and its valid bit
    typedef struct packed {
        logic   v;
        fixed_t prod;
    } stage1_t;

    // Clamp a full-width product into the N-bit signed range
    function automatic fixed_t sat_n(input wide_t x);
        wide_t hi;
        wide_t lo;
        hi = NP'(MAXV);
        lo = NP'(MINV);
        if (x > hi) begin
            return MAXV;
        end else if (x < lo) begin
            return MINV;
        end else begin
            return N'(x);
        end
    endfunction

endpackage

// File: rtl/multiplicacion_sat.sv
// Registered signed N x N multiply by a constant gain, rescaled and saturated to N bits.
module multiplicacion_sat
    import integrador_saturado_pkg::*;
#(
    parameter fixed_t K = fixed_t'(2)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    enable,
    input  fixed_t  e,
    output stage1_t s1
);

    wide_t  p;
    wide_t  p_sh;
    fixed_t p_sat;

    // Full-width product, arithmetic shift back to the word format, then clamp
    always_comb begin
        p     = NP'(e) * NP'(K);
        p_sh  = p >>> DECIMAL;
        p_sat = sat_n(p_sh);
    end

    // Capture the scaled sample on each strobe; clear discards it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
        end else if (clear) begin
            s1.v <= 1'b0;
        end else begin
            s1.v <= enable;
            if (enable) begin
                s1.prod <= p_sat;
            end
        end
    end

endmodule

// File: rtl/integrador_saturado.sv
// Integral term of the servo PID: scaled error accumulated with symmetric clamp,
// anti-windup hold and synchronous clear.
module integrador_saturado
    import integrador_saturado_pkg::*;
#(
    parameter int KI  = 2,
    parameter int LIM = int'(MAXV)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   clear,
    input  logic   hold,
    input  fixed_t e,
    output fixed_t integral,
    output logic   valid,
    output logic   sat_hi,
    output logic   sat_lo
);

    localparam fixed_t KI_W   = fixed_t'(KI);
    localparam sum_t   LIM_HI = sum_t'(LIM);
    localparam sum_t   LIM_LO = -LIM_HI;

    stage1_t s1;

    sum_t   sum;
    fixed_t integral_n;
    logic   valid_n;
    logic   sat_hi_n;
    logic   sat_lo_n;

    multiplicacion_sat #(
        .K (KI_W)
    ) u_mult (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .e      (e),
        .s1     (s1)
    );

    // Stage 2: accumulate one bit wider, clamp to +/-LIM, honour clear and hold
    always_comb begin
        sum        = (N+1)'(integral) + (N+1)'(s1.prod);
        integral_n = integral;
        sat_hi_n   = sat_hi;
        sat_lo_n   = sat_lo;
        valid_n    = 1'b0;
        if (clear) begin
            integral_n = '0;
            sat_hi_n   = 1'b0;
            sat_lo_n   = 1'b0;
        end else if (s1.v) begin
            valid_n = 1'b1;
            if (!hold) begin
                if (sum > LIM_HI) begin
                    integral_n = N'(LIM_HI);
                    sat_hi_n   = 1'b1;
                    sat_lo_n   = 1'b0;
                end else if (sum < LIM_LO) begin
                    integral_n = N'(LIM_LO);
                    sat_hi_n   = 1'b0;
                    sat_lo_n   = 1'b1;
                end else begin
                    integral_n = N'(sum);
                    sat_hi_n   = 1'b0;
                    sat_lo_n   = 1'b0;
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            integral <= '0;
            valid    <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else begin
            integral <= integral_n;
            valid    <= valid_n;
            sat_hi   <= sat_hi_n;
            sat_lo   <= sat_lo_n;
        end
    end

endmodule

// File: tb/tb_integrador_saturado.sv
// Randomized and directed check of integrador_saturado against an arithmetic model.
module tb_integrador_saturado;

    localparam int     KI     = 2;
    localparam int     LIM    = 1000;
    localparam longint WMAX   = 262143;
    localparam longint WMIN   = -262144;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               clear;
    logic               hold;
    logic signed [18:0] e;
    logic signed [18:0] integral;
    logic               valid;
    logic               sat_hi;
    logic               sat_lo;

    int n_cmp;
    int n_bad;

    // Behavioural model state: accumulated value, flags, and samples still in flight
    longint m_acc;
    bit     m_hi;
    bit     m_lo;
    bit     m_valid;
    longint inflight[$];

    integrador_saturado #(
        .KI  (KI),
        .LIM (LIM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .hold     (hold),
        .e        (e),
        .integral (integral),
        .valid    (valid),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic model_zero();
        m_acc   = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_valid = 0;
        inflight.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".integral"}, longint'(integral), m_acc);
        chk({tag, ".valid"},    longint'(valid),    longint'(m_valid));
        chk({tag, ".sat_hi"},   longint'(sat_hi),   longint'(m_hi));
        chk({tag, ".sat_lo"},   longint'(sat_lo),   longint'(m_lo));
    endtask

    // One clock: drive inputs, advance model at the edge, compare shortly after
    task automatic step(input bit en, input int ev, input bit clr, input bit hld, input string tag);
        longint s;
        enable = en;
        e      = 19'(ev);
        clear  = clr;
        hold   = hld;
        @(posedge clk);
        if (!reset) begin
            model_zero();
        end else if (clr) begin
            model_zero();
        end else begin
            m_valid = 0;
            if (inflight.size() > 0) begin
                s = inflight.pop_front();
                m_valid = 1;
                if (!hld) begin
                    s = m_acc + s;
                    m_hi  = s > LIM;
                    m_lo  = s < -LIM;
                    m_acc = clampl(s, -LIM, LIM);
                end
            end
            if (en) inflight.push_back(clampl(longint'(ev) * KI, WMIN, WMAX));
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        hold   = 1'b0;
        e      = '0;
        model_zero();

        // Reset held: toggling inputs has no effect
        #2;
        check_all("rst0");
        step(1, 10, 0, 0, "rst1");
        step(1, 300, 0, 1, "rst2");
        step(1, -5, 1, 0, "rst3");
        reset = 1'b1;
        step(0, 0, 0, 0, "rel1");
        step(0, 0, 0, 0, "rel2");

        // Streaming: three strobes of e=10
        step(1, 10, 0, 0, "str0");
        step(1, 10, 0, 0, "str1");
        chk("str_20", longint'(integral), 20);
        step(1, 10, 0, 0, "str2");
        chk("str_40", longint'(integral), 40);
        step(0, 0, 0, 0, "str3");
        chk("str_60", longint'(integral), 60);
        chk("str_v", longint'(valid), 1);
        step(0, 0, 0, 0, "str4");
        chk("str_vlow", longint'(valid), 0);

        // Positive clamp then release
        step(0, 0, 1, 0, "pc_clr");
        step(1, 300, 0, 0, "pc0");
        step(1, 300, 0, 0, "pc1");
        chk("pc_600", longint'(integral), 600);
        step(1, -100, 0, 0, "pc2");
        chk("pc_1000", longint'(integral), 1000);
        chk("pc_hi", longint'(sat_hi), 1);
        step(0, 0, 0, 0, "pc3");
        chk("pc_800", longint'(integral), 800);
        chk("pc_hi0", longint'(sat_hi), 0);

        // Negative clamp
        step(0, 0, 1, 0, "nc_clr");
        step(1, -400, 0, 0, "nc0");
        step(1, -400, 0, 0, "nc1");
        chk("nc_m800", longint'(integral), -800);
        step(1, -400, 0, 0, "nc2");
        chk("nc_m1000", longint'(integral), -1000);
        chk("nc_lo", longint'(sat_lo), 1);
        step(0, 0, 0, 0, "nc3");

        // Product saturation
        step(0, 0, 1, 0, "ps_clr");
        step(1, 262143, 0, 0, "ps0");
        step(0, 0, 0, 0, "ps1");
        chk("ps_1000", longint'(integral), 1000);
        chk("ps_hi", longint'(sat_hi), 1);
        step(0, 0, 1, 0, "ps_clr2");
        step(1, -262144, 0, 0, "ps2");
        step(0, 0, 0, 0, "ps3");
        chk("ps_m1000", longint'(integral), -1000);

        // Hold freezes the accumulator but still pulses valid
        step(0, 0, 1, 0, "hd_clr");
        step(1, 10, 0, 0, "hd0");
        step(1, 10, 0, 0, "hd1");
        step(1, 10, 0, 0, "hd2");
        step(1, 50, 0, 0, "hd3");
        step(1, 50, 0, 1, "hd4");
        chk("hd_60", longint'(integral), 60);
        chk("hd_v", longint'(valid), 1);
        step(0, 0, 0, 0, "hd5");
        chk("hd_160", longint'(integral), 160);

        // Clear wins over a concurrent strobe and over the in-flight sample
        step(0, 0, 1, 0, "cl_clr");
        step(1, 10, 0, 0, "cl0");
        step(1, 10, 0, 0, "cl1");
        step(1, 10, 0, 0, "cl2");
        step(1, 10, 1, 0, "cl3");
        chk("cl_0", longint'(integral), 0);
        chk("cl_v0", longint'(valid), 0);
        step(0, 0, 0, 0, "cl4");
        chk("cl_nov", longint'(valid), 0);
        step(1, 7, 0, 0, "cl5");
        step(0, 0, 0, 0, "cl6");
        chk("cl_14", longint'(integral), 14);

        // Reset asserted between edges one cycle after a strobe
        step(1, 10, 0, 0, "rm0");
        #2;
        reset = 1'b0;
        model_zero();
        #1;
        check_all("rm_imm");
        step(0, 0, 0, 0, "rm1");
        step(0, 0, 0, 0, "rm2");
        reset = 1'b1;
        step(0, 0, 0, 0, "rm3");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit en;
            bit clr;
            bit hld;
            int ev;
            en  = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 49) == 0);
            hld = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0)
                ev = int'($urandom_range(0, 524287)) - 262144;
            else
                ev = int'($urandom_range(0, 1200)) - 600;
            step(en, ev, clr, hld, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/integrador_saturado.md
Name: integrador_saturado

Overview:
Discrete-time integral term of the servo PID controller, the counterpart of the derivative path. On each sample strobe it multiplies the signed error sample by a fixed gain KI and adds the product into a saturating accumulator. Anti-windup hold and a synchronous clear are provided. The registered integral feeds the PID summing stage, in the same fixed-point format as the proportional and derivative terms.

Parameters:
Magnitud, 18, integer bits of the fixed-point word (excluding sign).
Decimal, 0, fractional bits of the fixed-point word.
N, Magnitud+Decimal+1, total signed word width.
KI, 2, signed N-bit integral gain in the same fixed-point format.
LIM, 2^(N-1)-1, positive clamp magnitude; integral is kept within [-LIM, +LIM].

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  sample strobe; e is captured on cycles where enable=1.
clear  input  1  synchronous accumulator clear, active-high.
hold  input  1  anti-windup freeze, active-high; sampled together with stage-2 data.
e  input  N signed  error sample.
integral  output  N signed  accumulated integral, registered.
valid  output  1  one-cycle pulse per processed sample.
sat_hi  output  1  last update clamped at +LIM.
sat_lo  output  1  last update clamped at -LIM.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0, all registers are 0: integral, valid, sat_hi, sat_lo, and the pipeline registers with their valid bits.
- Stage 1 (cycle t, enable=1):
  - Form the full 2N-bit product p = e*KI.
  - Shift p arithmetically right by Decimal, truncating toward -inf.
  - Saturate the result to the N-bit signed range.
  - Register the result as prod_r and set v1=1.
  - When enable=0, v1=0.
- Stage 2 (cycle t+1, v1=1):
  - Compute s = integral + prod_r at N+1 bits.
  - If s > LIM: integral <= LIM, sat_hi <= 1.
  - If s < -LIM: integral <= -LIM, sat_lo <= 1.
  - Otherwise: integral <= s, both flags cleared.
  - valid <= 1 at the same edge.
- Latency and throughput: the sample presented at edge t is reflected on integral and valid after edge t+2. Throughput is one sample per clock, so back-to-back strobes each accumulate.
- hold=1 with v1=1: integral and flags are unchanged, valid still pulses. hold is ignored when v1=0.
- clear=1:
  - integral, sat_hi, sat_lo, v1 and valid are all set to 0 at the next edge.
  - clear has priority over enable, hold and any stage-2 update; an in-flight sample is discarded.
  - A sample strobed in the cycle after clear deasserts is processed normally.
- Flags are mutually exclusive and update only on stage-2 updates or clear.
- Reset asserted mid-operation: all state is dropped immediately and no valid pulse is produced. Operation resumes with the first strobe after reset deasserts.
- Invariant: -LIM <= integral <= LIM at all times. The -2^(N-1) code is never produced.

Decomposition:
- Shared package/header holds:
  - fixed-point constants: N, Decimal, MAXV=2^(N-1)-1, MINV=-2^(N-1);
  - a saturate-to-N function reused by the other PID terms.
- One natural sub-module: multiplicacion_sat, which does the signed N x N multiply, the Decimal shift and the N-bit saturation, with a registered output.
- Accumulate, clamp and control logic stay in integrador_saturado.

Test Plan:
Bench settings: N=19, Decimal=0, KI=2, LIM=1000.
1. Reset: hold reset=0 and toggle inputs -> integral=0, valid=0, sat_hi=sat_lo=0. Release reset -> still 0 until the first strobe.
2. Streaming: enable=1 for 3 consecutive cycles with e=10 -> integral 20, 40, 60 on cycles t+2, t+3, t+4, valid high on each of those cycles.
3. Positive clamp: e=300 twice -> 600, then 1000 with sat_hi=1. Then e=-100 -> 800 with sat_hi=0.
4. Negative clamp and product saturation:
   - from 0, e=-400 twice -> -800, then -1000 with sat_lo=1;
   - after clear, e=262143 -> product saturates to 262143, integral clamps to 1000, sat_hi=1.
5. Hold: integral=60, hold=1, e=50 -> integral stays 60, valid pulses, flags unchanged. Then hold=0, e=50 -> 160.
6. Clear and reset priority:
   - integral=60, clear=1 in the same cycle as enable with e=10 -> integral=0 and no valid from that sample;
   - separately, assert reset one cycle after a strobe -> outputs 0 immediately and no valid pulse.
